duck_round_ctrl: RTL and testbench
==================================

Name: duck_round_ctrl

Overview:
- Game-level sequencer for the duck hunt display pipeline.
- Starts the dog intro animation, then launches ducks one at a time. Per duck it arbitrates shots, hits and fly-away timeout, and orders the fall or flee animation.
- Tallies hits per round, keeps score and decides round advance or game over.
- Sits above the dog/duck animation control. Its outputs are used as handshakes and HUD data.

Parameters:
- DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
- SHOTS_PER_DUCK, 3, shots allowed per duck (1..3)
- FLY_TIMEOUT, 50, Frame_tick count in FLY before the duck flees
- FALL_FRAMES, 12, Frame_tick count of the fall animation
- FLEE_FRAMES, 15, Frame_tick count of the flee animation
- PASS_HITS, 6, minimum hits in a round needed to advance
- SCORE_PER_HIT, 500, score added per hit

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  level; begins a game from IDLE or GAME_OVER
- Frame_tick  in  1  one-Clk pulse per animation frame
- Intro_done  in  1  dog intro animation complete (pulse or level)
- Shot  in  1  one-Clk trigger pulse
- Hit  in  1  qualifies Shot; duck was under the crosshair
- Intro_go  out  1  held high in INTRO
- Duck_launch  out  1  one-Clk pulse; start a new duck
- Duck_fall  out  1  high in FALL
- Duck_flee  out  1  high in FLEE
- Shots_left  out  2  shots remaining for the current duck
- Duck_index  out  4  current duck, 0-based
- Hit_mask  out  16  bit i set when duck i of this round was hit
- Round  out  4  round number, starts at 1
- Score  out  16  running score
- Game_over  out  1  high in GAME_OVER

Behaviour:
- All state changes happen on rising Clk. Reset takes priority over every other input.
- Reset values:
  - state IDLE
  - Shots_left 0, Duck_index 0, Hit_mask 0, Round 0, Score 0, frame counter 0
  - all pulse/level outputs 0
- A Reset asserted in any state aborts the game the next cycle.
- Frame counter:
  - 7 bits, counts Frame_tick only.
  - Cleared on every state entry.
- IDLE:
  - Start=1 -> INTRO.
  - On that transition: Round<=1, Score<=0, Hit_mask<=0, Duck_index<=0.
- INTRO:
  - Intro_go=1.
  - Intro_done=1 -> LAUNCH.
- LAUNCH:
  - Lasts exactly one cycle; Duck_launch=1.
  - Shots_left<=SHOTS_PER_DUCK.
  - Next state is FLY.
- FLY: evaluated in this priority order each cycle.
  1. Shot&Hit with Shots_left>0:
     - Shots_left-1, Hit_mask[Duck_index]<=1.
     - Score<=min(Score+SCORE_PER_HIT, 16'hFFFF).
     - -> FALL.
  2. Shot&~Hit with Shots_left>0:
     - Shots_left-1.
     - If the result is 0 -> FLEE, else stay.
  3. Frame counter reaches FLY_TIMEOUT -> FLEE.
- FLY boundary cases:
  - Shot together with timeout: the shot is processed first; a hit wins over the timeout.
  - Shot while Shots_left==0: ignored.
  - Hit without Shot: ignored.
- Shots outside FLY are ignored; Shots_left, Score and Hit_mask do not change.
- FALL: Duck_fall=1; after FALL_FRAMES ticks -> TALLY.
- FLEE: Duck_flee=1; after FLEE_FRAMES ticks -> TALLY.
- TALLY (one cycle):
  - Duck_index==DUCKS_PER_ROUND-1 -> ROUND_END.
  - Otherwise Duck_index+1 -> LAUNCH.
- ROUND_END (one cycle):
  - Hit count is the popcount of Hit_mask.
  - Count >= PASS_HITS:
    - Round<=Round+1, saturating at 15.
    - Hit_mask<=0, Duck_index<=0.
    - -> INTRO.
  - Otherwise -> GAME_OVER.
- GAME_OVER:
  - Game_over=1; Score, Round and Hit_mask are held for display.
  - Start=1 -> INTRO with the same initialisation as in IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Latency: Shot to an updated Shots_left or Score is one cycle.

Test Plan:
- Reset mid-FLY with Score=1500 -> next cycle state IDLE; Score 0, Round 0, all pulse outputs 0.
- Start, Intro_done after 5 cycles -> Intro_go high 5 cycles, a single Duck_launch pulse, Shots_left=3.
- In FLY, Shot&~Hit twice then Shot&Hit -> Shots_left 3→2→1→0, Hit_mask[0]=1, Score=500, Duck_fall high for 12 ticks, then Duck_index=1.
- Three misses -> Duck_flee on the cycle after the third shot. No shots and 50 ticks -> FLEE. Shot&Hit on the same cycle as the 50th tick -> FALL.
- A round with 6 hits out of 10 -> Round=2, Hit_mask=0, INTRO re-entered. A round with 5 hits -> Game_over=1 with Score held; then Start -> INTRO, Score 0.
- Score preset near saturation (131 hits) -> Score=16'hFFFF, no wrap. Round 15 passed -> Round stays 15.

Source files
------------

// File: rtl/duck_round_ctrl.sv
// Game-level sequencer for duck hunt: dog intro, per-duck shot/hit/timeout arbitration,
// fall/flee animation ordering, per-round hit tally, score and round advance or game over.
module duck_round_ctrl #(
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned SHOTS_PER_DUCK  = 3,
  parameter int unsigned FLY_TIMEOUT     = 50,
  parameter int unsigned FALL_FRAMES     = 12,
  parameter int unsigned FLEE_FRAMES     = 15,
  parameter int unsigned PASS_HITS       = 6,
  parameter int unsigned SCORE_PER_HIT   = 500
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Frame_tick,
  input  logic        Intro_done,
  input  logic        Shot,
  input  logic        Hit,
  output logic        Intro_go,
  output logic        Duck_launch,
  output logic        Duck_fall,
  output logic        Duck_flee,
  output logic [1:0]  Shots_left,
  output logic [3:0]  Duck_index,
  output logic [15:0] Hit_mask,
  output logic [3:0]  Round,
  output logic [15:0] Score,
  output logic        Game_over
);

  localparam logic [7:0]  FlyTimeout = 8'(FLY_TIMEOUT);
  localparam logic [7:0]  FallFrames = 8'(FALL_FRAMES);
  localparam logic [7:0]  FleeFrames = 8'(FLEE_FRAMES);
  localparam logic [4:0]  PassHits   = 5'(PASS_HITS);
  localparam logic [1:0]  ShotsFull  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]  LastDuck   = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [16:0] HitPoints  = 17'(SCORE_PER_HIT);

  typedef enum logic [3:0] {
    StIdle,
    StIntro,
    StLaunch,
    StFly,
    StFall,
    StFlee,
    StTally,
    StRoundEnd,
    StGameOver
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  frame_cnt_q;
  logic [7:0]  cnt_plus;
  logic        shot_ok;
  logic [4:0]  hit_cnt;
  logic        round_pass;
  logic [16:0] score_sum;
  logic [15:0] score_sat;

  // Count including this cycle's tick, so a limit is reached on the tick itself
  assign cnt_plus   = {1'b0, frame_cnt_q} + {7'd0, Frame_tick};
  assign shot_ok    = Shot && (Shots_left != 2'd0);
  assign score_sum  = {1'b0, Score} + HitPoints;
  assign score_sat  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign round_pass = (hit_cnt >= PassHits);

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      hit_cnt = hit_cnt + {4'd0, Hit_mask[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (Start) state_d = StIntro;
      StIntro:    if (Intro_done) state_d = StLaunch;
      StLaunch:   state_d = StFly;
      StFly: begin
        if (shot_ok && Hit) begin
          state_d = StFall;
        end else if (shot_ok) begin
          if (Shots_left == 2'd1) state_d = StFlee;
        end else if (cnt_plus >= FlyTimeout) begin
          state_d = StFlee;
        end
      end
      StFall:     if (cnt_plus >= FallFrames) state_d = StTally;
      StFlee:     if (cnt_plus >= FleeFrames) state_d = StTally;
      StTally:    state_d = (Duck_index == LastDuck) ? StRoundEnd : StLaunch;
      StRoundEnd: state_d = round_pass ? StIntro : StGameOver;
      StGameOver: if (Start) state_d = StIntro;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      Shots_left  <= '0;
      Duck_index  <= '0;
      Hit_mask    <= '0;
      Round       <= '0;
      Score       <= '0;
      Intro_go    <= 1'b0;
      Duck_launch <= 1'b0;
      Duck_fall   <= 1'b0;
      Duck_flee   <= 1'b0;
      Game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      Intro_go    <= (state_d == StIntro);
      Duck_launch <= (state_d == StLaunch);
      Duck_fall   <= (state_d == StFall);
      Duck_flee   <= (state_d == StFlee);
      Game_over   <= (state_d == StGameOver);

      if (state_d != state_q) begin
        frame_cnt_q <= '0;
      end else if (Frame_tick && (frame_cnt_q != 7'h7F)) begin
        frame_cnt_q <= frame_cnt_q + 7'd1;
      end

      case (state_q)
        StIdle, StGameOver: begin
          if (Start) begin
            Round      <= 4'd1;
            Score      <= '0;
            Hit_mask   <= '0;
            Duck_index <= '0;
          end
        end
        StLaunch: Shots_left <= ShotsFull;
        StFly: begin
          if (shot_ok) begin
            Shots_left <= Shots_left - 2'd1;
            if (Hit) begin
              Hit_mask[Duck_index] <= 1'b1;
              Score                <= score_sat;
            end
          end
        end
        StTally: begin
          if (Duck_index != LastDuck) Duck_index <= Duck_index + 4'd1;
        end
        StRoundEnd: begin
          if (round_pass) begin
            Round      <= (Round == 4'd15) ? 4'd15 : Round + 4'd1;
            Hit_mask   <= '0;
            Duck_index <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: a fixed table round, randomized rounds against a duck-level
// game model (hits, score, mask, round), plus reset, game-over and saturation sequences.
module tb_duck_round_ctrl;

  localparam int DPR    = 10;
  localparam int SPD    = 3;
  localparam int FLY_TO = 50;
  localparam int FALL_F = 12;
  localparam int FLEE_F = 15;
  localparam int PASS   = 6;
  localparam int SPH    = 500;

  localparam int MHit     = 0;  // k misses then a hit
  localparam int MMiss    = 1;  // all shots missed
  localparam int MTimeout = 2;  // k misses then fly-away
  localparam int MTimeHit = 3;  // k misses then hit on the timeout tick

  logic Clk = 1'b0;
  logic Reset = 1'b1, Start = 1'b0, Frame_tick = 1'b0, Intro_done = 1'b0;
  logic Shot = 1'b0, Hit = 1'b0;
  logic Intro_go, Duck_launch, Duck_fall, Duck_flee, Game_over;
  logic [1:0]  Shots_left;
  logic [3:0]  Duck_index, Round;
  logic [15:0] Hit_mask, Score;

  int n_tests = 0;
  int n_fail  = 0;

  // Game model
  int          exp_score, exp_round, exp_index, exp_sl, round_hits;
  logic [15:0] exp_mask;
  int          round_mode [DPR];
  int          round_miss [DPR];

  typedef struct {
    int n_miss;
    int mode;
    int exp_fell;
    int exp_sl;
  } vec_t;
  vec_t tbl [DPR];

  always #5 Clk = ~Clk;

  duck_round_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Frame_tick (Frame_tick),
    .Intro_done (Intro_done),
    .Shot       (Shot),
    .Hit        (Hit),
    .Intro_go   (Intro_go),
    .Duck_launch(Duck_launch),
    .Duck_fall  (Duck_fall),
    .Duck_flee  (Duck_flee),
    .Shots_left (Shots_left),
    .Duck_index (Duck_index),
    .Hit_mask   (Hit_mask),
    .Round      (Round),
    .Score      (Score),
    .Game_over  (Game_over)
  );

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic id, input logic s, input logic h,
                      input logic t);
    Start = st; Intro_done = id; Shot = s; Hit = h; Frame_tick = t;
    @(posedge Clk);
    #1;
  endtask

  task automatic new_game_model();
    exp_score = 0; exp_round = 1; exp_mask = '0; exp_index = 0; round_hits = 0;
  endtask

  // Entered INTRO on the previous edge; leaves in LAUNCH
  task automatic do_intro(input int w);
    check("intro_go_entry", int'(Intro_go), 1);
    for (int i = 0; i < w; i++) begin
      step(1'b0, 1'b0, rb(), rb(), rb());
      check("intro_go_held", int'(Intro_go), 1);
      check("no_launch_in_intro", int'(Duck_launch), 0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("intro_go_drop", int'(Intro_go), 0);
  endtask

  // Entered LAUNCH on the previous edge; leaves after TALLY
  task automatic run_duck(input int n_miss, input int mode, output int fell, output int sl_out);
    int   fly_ticks, frames, ticks, gap, fell_l;
    logic t;
    check("launch_pulse", int'(Duck_launch), 1);
    check("duck_index", int'(Duck_index), exp_index);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("launch_once", int'(Duck_launch), 0);
    exp_sl = SPD;
    check("shots_full", int'(Shots_left), exp_sl);
    fly_ticks = 0;
    for (int m = 0; m < n_miss; m++) begin
      t = rb();
      step(1'b0, 1'b0, 1'b1, 1'b0, t);
      fly_ticks += int'(t);
      exp_sl--;
      check("shots_after_miss", int'(Shots_left), exp_sl);
      check("flee_after_miss", int'(Duck_flee), int'(exp_sl == 0));
    end
    if (exp_sl == 0) begin
      fell_l = 0;
    end else if (mode == MHit) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, rb());
      fell_l = 1;
    end else begin
      while (fly_ticks < FLY_TO - 1) begin
        step(1'b0, 1'b0, 1'b0, rb(), 1'b1);
        fly_ticks++;
      end
      check("pre_timeout_fly", int'(Duck_fall | Duck_flee), 0);
      check("hit_no_shot_ignored", int'(Shots_left), exp_sl);
      if (mode == MTimeHit) begin
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        fell_l = 1;
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        fell_l = 0;
      end
    end
    if (fell_l != 0) begin
      exp_sl--;
      exp_mask[exp_index] = 1'b1;
      round_hits++;
      exp_score = (exp_score + SPH > 65535) ? 65535 : exp_score + SPH;
    end
    check("fall_out", int'(Duck_fall), fell_l);
    check("flee_out", int'(Duck_flee), int'(fell_l == 0));
    check("shots_left", int'(Shots_left), exp_sl);
    check("score", int'(Score), exp_score);
    check("hit_mask", int'(Hit_mask), int'(exp_mask));

    frames = (fell_l != 0) ? FALL_F : FLEE_F;
    ticks  = 0;
    gap    = 0;
    while (ticks < frames) begin
      t = (gap >= 2) ? 1'b1 : rb();
      if (t && ticks == frames - 1)
        check("anim_held", int'((fell_l != 0) ? Duck_fall : Duck_flee), 1);
      step(rb(), 1'b0, rb(), rb(), t);
      if (t) begin ticks++; gap = 0; end
      else gap++;
    end
    check("tally_quiet", int'(Duck_fall | Duck_flee | Duck_launch), 0);
    check("score_outside_fly", int'(Score), exp_score);
    check("shots_outside_fly", int'(Shots_left), exp_sl);
    check("mask_outside_fly", int'(Hit_mask), int'(exp_mask));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (exp_index < DPR - 1) exp_index++;
    fell   = fell_l;
    sl_out = exp_sl;
  endtask

  task automatic gen_round(input int n_hits);
    int j, tm;
    for (int d = 0; d < DPR; d++) begin
      if (d < n_hits) begin
        round_mode[d] = rb() ? MHit : MTimeHit;
        round_miss[d] = int'($urandom_range(0, SPD - 1));
      end else if (rb()) begin
        round_mode[d] = MMiss;
        round_miss[d] = SPD;
      end else begin
        round_mode[d] = MTimeout;
        round_miss[d] = int'($urandom_range(0, SPD - 1));
      end
    end
    for (int d = DPR - 1; d > 0; d--) begin
      j = int'($urandom_range(0, d));
      tm = round_mode[d]; round_mode[d] = round_mode[j]; round_mode[j] = tm;
      tm = round_miss[d]; round_miss[d] = round_miss[j]; round_miss[j] = tm;
    end
  endtask

  task automatic play_round(input int intro_wait, input bit use_table);
    int fell, sl;
    round_hits = 0;
    do_intro(intro_wait);
    for (int d = 0; d < DPR; d++) begin
      run_duck(round_miss[d], round_mode[d], fell, sl);
      if (use_table) begin
        check("vec_fell", fell, tbl[d].exp_fell);
        check("vec_shots", sl, tbl[d].exp_sl);
      end
    end
    if (use_table) begin
      check("tbl_mask", int'(Hit_mask), 16'h02B9);
      check("tbl_score", int'(Score), 3000);
    end
    check("round_end_quiet", int'(Intro_go | Game_over | Duck_launch), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (round_hits >= PASS) begin
      exp_round = (exp_round == 15) ? 15 : exp_round + 1;
      exp_mask  = '0;
      exp_index = 0;
      check("next_intro", int'(Intro_go), 1);
      check("round_adv", int'(Round), exp_round);
      check("mask_clr", int'(Hit_mask), 0);
      check("index_clr", int'(Duck_index), 0);
    end else begin
      check("game_over", int'(Game_over), 1);
      check("round_held", int'(Round), exp_round);
      check("score_held", int'(Score), exp_score);
      check("mask_held", int'(Hit_mask), int'(exp_mask));
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fell, sl;
    tbl[0] = '{2, MHit,     1, 0};
    tbl[1] = '{3, MMiss,    0, 0};
    tbl[2] = '{0, MTimeout, 0, 3};
    tbl[3] = '{0, MTimeHit, 1, 2};
    tbl[4] = '{1, MHit,     1, 1};
    tbl[5] = '{0, MHit,     1, 2};
    tbl[6] = '{1, MTimeout, 0, 2};
    tbl[7] = '{2, MTimeHit, 1, 0};
    tbl[8] = '{2, MTimeout, 0, 1};
    tbl[9] = '{0, MHit,     1, 2};

    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    check("rst_shots", int'(Shots_left), 0);
    check("rst_index", int'(Duck_index), 0);
    check("rst_mask", int'(Hit_mask), 0);
    check("rst_round", int'(Round), 0);
    check("rst_score", int'(Score), 0);
    check("rst_pulses", int'(Intro_go | Duck_launch | Duck_fall | Duck_flee | Game_over), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("idle_holds", int'(Intro_go), 0);

    // Game 1: table round passes, random 5-hit round ends the game
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    new_game_model();
    check("start_round", int'(Round), 1);
    for (int d = 0; d < DPR; d++) begin
      round_mode[d] = tbl[d].mode;
      round_miss[d] = tbl[d].n_miss;
    end
    play_round(4, 1'b1);
    gen_round(5);
    play_round(int'($urandom_range(0, 3)), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, rb(), rb(), rb(), rb());
      check("over_held", int'(Game_over), 1);
      check("over_score", int'(Score), exp_score);
      check("over_shots", int'(Shots_left), exp_sl);
    end

    // Restart from GAME_OVER, then reset in the middle of FLY with 1500 points
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    new_game_model();
    check("restart_score", int'(Score), 0);
    check("restart_round", int'(Round), 1);
    check("restart_over", int'(Game_over), 0);
    do_intro(1);
    for (int d = 0; d < 3; d++) run_duck(0, MHit, fell, sl);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_score", int'(Score), 1500);
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    check("midfly_rst_score", int'(Score), 0);
    check("midfly_rst_round", int'(Round), 0);
    check("midfly_rst_shots", int'(Shots_left), 0);
    check("midfly_rst_mask", int'(Hit_mask), 0);
    check("midfly_rst_pulses", int'(Intro_go | Duck_launch | Duck_fall | Duck_flee | Game_over), 0);

    // Game 2: fifteen perfect rounds drive score and round into saturation
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    new_game_model();
    for (int r = 0; r < 15; r++) begin
      gen_round(10);
      play_round(int'($urandom_range(0, 3)), 1'b0);
    end
    check("score_saturated", int'(Score), 65535);
    check("round_saturated", int'(Round), 15);
    gen_round(int'($urandom_range(0, PASS - 1)));
    play_round(int'($urandom_range(0, 3)), 1'b0);
    check("final_over", int'(Game_over), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
